// File: rtl/shared_pkg.sv
// Shared command encoding for the SPI slave and its RAM back-ends.
// The opcode sits directly above the data payload in every din word.
package shared_pkg;

  typedef enum logic [1:0] {
    WRITE_ADDR = 2'b00,
    WRITE_DATA = 2'b01,
    READ_ADDR  = 2'b10,
    READ_DATA  = 2'b11
  } op_e;

  // Opcode bit positions counted from the top of the payload (din[DW+OP_MSB:DW+OP_LSB]).
  localparam int OP_MSB = 1;
  localparam int OP_LSB = 0;

  typedef enum logic {WR_IDLE, WR_ARMED} wr_state_e;
  typedef enum logic {RD_IDLE, RD_ARMED} rd_state_e;

  function automatic op_e op_decode(input logic [OP_MSB:OP_LSB] op_bits);
    return op_e'(op_bits);
  endfunction

endpackage

// File: rtl/ram_sp_core.sv
// Single-port RAM with a registered read port; the array and read register have no reset.
// rdata updates one cycle after re and holds otherwise.
module ram_sp_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-slave RAM: address/data commands with optional burst auto-increment and read-only lock.
// Read data and tx_valid appear one cycle after READ_DATA; rejected commands pulse err.
module spi_ram_burst
  import shared_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] din,
  input  logic                  rx_valid,
  input  logic                  ro_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  tx_valid,
  output logic                  err
);

  op_e                   op;
  wr_state_e             wr_state;
  rd_state_e             rd_state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_cmd;
  logic                  rd_cmd;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rd_seen;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign op     = op_decode(din[DATA_WIDTH+OP_MSB:DATA_WIDTH+OP_LSB]);
  assign wr_cmd = rx_valid && (op == WRITE_DATA);
  assign rd_cmd = rx_valid && (op == READ_DATA);
  assign wr_ok  = wr_cmd && (wr_state == WR_ARMED) && !ro_en;
  assign rd_ok  = rd_cmd && (rd_state == RD_ARMED);

  ram_sp_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .addr (wr_ok ? wr_ptr : rd_ptr),
    .wdata(din[DATA_WIDTH-1:0]),
    .re   (rd_ok),
    .rdata(ram_rdata)
  );

  // The RAM read register has no reset, so dout is forced to zero until a read lands.
  assign dout = rd_seen ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_seen  <= 1'b0;
      tx_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      tx_valid <= rd_ok;
      err      <= (wr_cmd && !wr_ok) || (rd_cmd && !rd_ok);
      if (rd_ok) rd_seen <= 1'b1;
      if (rx_valid) begin
        case (op)
          WRITE_ADDR: begin
            wr_ptr   <= din[ADDR_WIDTH-1:0];
            wr_state <= WR_ARMED;
          end
          READ_ADDR: begin
            rd_ptr   <= din[ADDR_WIDTH-1:0];
            rd_state <= RD_ARMED;
          end
          WRITE_DATA: if (wr_ok && AUTO_INC) wr_ptr <= wr_ptr + 1'b1;
          READ_DATA:  if (rd_ok && AUTO_INC) rd_ptr <= rd_ptr + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench: a burst instance (AUTO_INC=1) and a fixed-pointer instance (AUTO_INC=0).
module tb_spi_ram_burst;
  import shared_pkg::*;

  typedef struct {
    logic       tx;
    logic       er;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] din_a, din_b;
  logic       rxv_a, rxv_b, ro_a, ro_b;
  logic [7:0] dout_a, dout_b;
  logic       txv_a, txv_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];

  // Reference model state, index 0 = burst instance, 1 = fixed-pointer instance
  logic [7:0] ref_mem [2][256];
  logic [7:0] wp [2];
  logic [7:0] rp [2];
  logic       wa [2];
  logic       ra [2];
  logic [7:0] last_d [2];
  logic       ai [2];

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .rx_valid(rxv_a), .ro_en(ro_a),
    .dout(dout_a), .tx_valid(txv_a), .err(err_a)
  );

  spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .AUTO_INC(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .rx_valid(rxv_b), .ro_en(ro_b),
    .dout(dout_b), .tx_valid(txv_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      wp[i] = '0; rp[i] = '0; wa[i] = 1'b0; ra[i] = 1'b0; last_d[i] = '0;
    end
  endtask

  // One command cycle on instance s: drive at negedge, model, then check #1 after posedge.
  task automatic step(input int s, input logic v, input op_e op, input logic [7:0] pay,
                      input logic ro);
    exp_t e, got;
    logic [7:0] d_obs;
    logic       t_obs, e_obs;
    e.tx = 1'b0; e.er = 1'b0; e.d = last_d[s];
    @(negedge clk);
    rxv_a = 1'b0; rxv_b = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    if (s == 0) begin din_a = {op, pay}; rxv_a = v; ro_a = ro; end
    else        begin din_b = {op, pay}; rxv_b = v; ro_b = ro; end
    if (v) begin
      case (op)
        WRITE_ADDR: begin wp[s] = pay; wa[s] = 1'b1; end
        READ_ADDR:  begin rp[s] = pay; ra[s] = 1'b1; end
        WRITE_DATA: begin
          if (wa[s] && !ro) begin
            ref_mem[s][wp[s]] = pay;
            if (ai[s]) wp[s] = wp[s] + 8'd1;
          end else e.er = 1'b1;
        end
        READ_DATA: begin
          if (ra[s]) begin
            e.tx = 1'b1;
            e.d  = ref_mem[s][rp[s]];
            rd_q.push_back(ref_mem[s][rp[s]]);
            if (ai[s]) rp[s] = rp[s] + 8'd1;
          end else e.er = 1'b1;
        end
        default: ;
      endcase
    end
    last_d[s] = e.d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rxv_a = 1'b0; rxv_b = 1'b0;
    d_obs = (s == 0) ? dout_a : dout_b;
    t_obs = (s == 0) ? txv_a : txv_b;
    e_obs = (s == 0) ? err_a : err_b;
    got = exp_q.pop_front();
    check("tx_valid", {31'd0, t_obs}, {31'd0, got.tx});
    check("err", {31'd0, e_obs}, {31'd0, got.er});
    if (t_obs) begin
      if (rd_q.size() == 0) check("unexpected_read_data", {24'd0, d_obs}, 32'hFFFF_FFFF);
      else                  check("read_data", {24'd0, d_obs}, {24'd0, rd_q.pop_front()});
    end else begin
      check("dout_hold", {24'd0, d_obs}, {24'd0, got.d});
    end
  endtask

  initial begin
    ai[0] = 1'b1; ai[1] = 1'b0;
    rst_n = 1'b0;
    din_a = '0; din_b = '0; rxv_a = 1'b0; rxv_b = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    model_reset();
    #12;
    check("rst_dout_a", {24'd0, dout_a}, 32'd0);
    check("rst_tx_a", {31'd0, txv_a}, 32'd0);
    check("rst_err_a", {31'd0, err_a}, 32'd0);
    check("rst_dout_b", {24'd0, dout_b}, 32'd0);
    check("rst_tx_b", {31'd0, txv_b}, 32'd0);
    check("rst_err_b", {31'd0, err_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read of 0x10
    step(0, 1, WRITE_ADDR, 8'h10, 0);
    step(0, 1, WRITE_DATA, 8'hA5, 0);
    step(0, 1, READ_ADDR,  8'h10, 0);
    step(0, 1, READ_DATA,  8'h00, 0);
    step(0, 0, READ_DATA,  8'h00, 0);

    // Burst across the top of memory: FE, FF, 00
    step(0, 1, WRITE_ADDR, 8'hFE, 0);
    step(0, 1, WRITE_DATA, 8'h11, 0);
    step(0, 1, WRITE_DATA, 8'h22, 0);
    step(0, 1, WRITE_DATA, 8'h33, 0);
    step(0, 1, READ_ADDR,  8'hFE, 0);
    for (int i = 0; i < 3; i++) step(0, 1, READ_DATA, 8'h00, 0);
    step(0, 0, WRITE_ADDR, 8'h00, 0);

    // Read-only lock: 0x06 preloaded, locked write must be rejected without moving the pointer
    step(0, 1, WRITE_ADDR, 8'h06, 0);
    step(0, 1, WRITE_DATA, 8'h5A, 0);
    step(0, 1, WRITE_ADDR, 8'h05, 0);
    step(0, 1, WRITE_DATA, 8'h77, 0);
    step(0, 1, WRITE_DATA, 8'h99, 1);
    step(0, 1, READ_ADDR,  8'h05, 0);
    step(0, 1, READ_DATA,  8'h00, 0);
    step(0, 1, READ_DATA,  8'h00, 1);

    // Preload 0x00 so the post-reset rejected write can be shown harmless
    step(0, 1, WRITE_ADDR, 8'h00, 0);
    step(0, 1, WRITE_DATA, 8'h44, 0);

    // Reset mid-burst: one read completes, the next is in flight when reset asserts
    step(0, 1, READ_ADDR, 8'h10, 0);
    step(0, 1, READ_DATA, 8'h00, 0);
    @(negedge clk);
    din_a = {READ_DATA, 8'h00}; rxv_a = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dout", {24'd0, dout_a}, 32'd0);
    check("midrst_tx", {31'd0, txv_a}, 32'd0);
    check("midrst_err", {31'd0, err_a}, 32'd0);
    rxv_a = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, READ_DATA, 8'h00, 0);
    step(0, 0, READ_DATA, 8'h00, 0);

    // Protocol errors straight after reset, then confirm 0x00 unchanged
    step(0, 1, READ_DATA,  8'h00, 0);
    step(0, 1, WRITE_DATA, 8'h3C, 0);
    step(0, 1, READ_ADDR,  8'h00, 0);
    step(0, 1, READ_DATA,  8'h00, 0);

    // Fixed-pointer instance: repeated writes/reads hit one address only
    step(1, 1, WRITE_ADDR, 8'h21, 0);
    step(1, 1, WRITE_DATA, 8'hC3, 0);
    step(1, 1, WRITE_ADDR, 8'h20, 0);
    step(1, 1, WRITE_DATA, 8'h01, 0);
    step(1, 1, WRITE_DATA, 8'h02, 0);
    step(1, 1, READ_ADDR,  8'h20, 0);
    step(1, 1, READ_DATA,  8'h00, 0);
    step(1, 1, READ_DATA,  8'h00, 0);
    step(1, 1, READ_ADDR,  8'h21, 0);
    step(1, 1, READ_DATA,  8'h00, 0);
    step(1, 0, READ_DATA,  8'h00, 0);

    if (rd_q.size() != 0) check("read_queue_drained", rd_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
